// File: rtl/bps_tick_ctrl.sv
// Baud/tick rate controller: owns the active divisor, defers run-time divisor
// changes to a period boundary, and emits a one-cycle tick plus a 50% clk_bps.
module bps_tick_ctrl #(
  parameter int CNT_W       = 14,
  parameter int DIV_DEFAULT = 10000
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high asynchronous reset despite the name
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic             clk_bps,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] div_act_q;
  logic [CNT_W-1:0] div_pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             clk_bps_q;
  logic             cfg_err_q;
  logic             cfg_ready_q;
  logic             busy_q;

  logic             cfg_fire;
  logic             cfg_legal;
  logic             wrap;
  logic [CNT_W-1:0] cnt_d;

  assign cfg_fire  = cfg_valid && cfg_ready_q;
  assign cfg_legal = (cfg_div >= CNT_W'(2));
  // div_act_q is always >= 2, so the subtraction cannot underflow.
  assign wrap      = (cnt_q == div_act_q - CNT_W'(1));
  assign cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      div_act_q   <= DIV_RST;
      div_pend_q  <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      clk_bps_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      // Illegal divisors still complete the handshake; only the error pulse reacts.
      cfg_err_q <= cfg_fire && !cfg_legal;
      tick_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q       <= '0;
          clk_bps_q   <= 1'b0;
          cfg_ready_q <= 1'b1;
          if (cfg_fire && cfg_legal) begin
            div_act_q <= cfg_div;
          end
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end

        RUN, PEND: begin
          if (!en) begin
            // Stopping commits whatever divisor is waiting or arriving now.
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            cnt_q       <= '0;
            clk_bps_q   <= 1'b0;
            if (state_q == PEND) begin
              div_act_q <= div_pend_q;
            end else if (cfg_fire && cfg_legal) begin
              div_act_q <= cfg_div;
            end
          end else begin
            cnt_q <= cnt_d;
            if (wrap) begin
              tick_q    <= 1'b1;
              clk_bps_q <= ~clk_bps_q;
            end

            if (state_q == PEND) begin
              if (wrap) begin
                div_act_q   <= div_pend_q;
                state_q     <= RUN;
                cfg_ready_q <= 1'b1;
              end
            end else if (cfg_fire && cfg_legal) begin
              // Even on a wrap edge the new value waits one full period.
              div_pend_q  <= cfg_div;
              state_q     <= PEND;
              cfg_ready_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
          cnt_q       <= '0;
          clk_bps_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign tick      = tick_q;
  assign clk_bps   = clk_bps_q;
  assign busy      = busy_q;

endmodule
